// File: rtl/pkt_rd_scheduler_if.sv
// Capture-memory read port and outgoing packet stream of pkt_rd_scheduler.
// The master side is the scheduler; the slave side is the memory and the packet consumer.
interface pkt_rd_scheduler_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 18
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              pkt_valid;
    logic [DATA_W-1:0] pkt_data;
    logic              pkt_sop;
    logic              pkt_eop;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output pkt_valid,
        output pkt_data,
        output pkt_sop,
        output pkt_eop
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  pkt_valid,
        input  pkt_data,
        input  pkt_sop,
        input  pkt_eop
    );
endinterface

// File: rtl/pkt_rd_scheduler.sv
// Paced, fixed-length packet reader for the capture memory, sharing the read port with MDIO debug reads.
// Define PKT_SCHED_HDR_EN to prefix every packet with a sequence-numbered header word.
module pkt_rd_scheduler #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned DATA_W    = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cfg_data_length,
    input  logic [1:0]          cfg_idle_length,
    input  logic [3:0]          cfg_gap,
    input  logic                capture_start,
    input  logic                capture_again,
    input  logic                mdio_rd_req,
    input  logic [ADDR_W-1:0]   mdio_rd_addr,
    output logic                mdio_rd_ack,
    output logic [DATA_W-1:0]   mdio_rd_data,
    output logic                busy,
    output logic                rd_done,
    pkt_rd_scheduler_if.master  bus
);

    localparam int unsigned WCNT_W = 11;
    localparam int unsigned PACE_W = 4;
    localparam int unsigned IDLE_W = 6;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [WCNT_W-1:0] BASE_LEN  = WCNT_W'(216);

    typedef enum logic [1:0] {IDLE, PKT, IDLE_GAP, DONE} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [PACE_W-1:0]  pace_q, pace_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               again_pend_q, again_pend_d;
    logic [1:0]         len_sel_q, len_sel_d;
    logic [1:0]         idle_sel_q, idle_sel_d;
    logic [PACE_W-1:0]  gap_q, gap_d;

    // Issue stage: the cycle mem_rd_en is on the memory port
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_pkt_q, rd_pkt_d;
    logic               rd_mdio_q, rd_mdio_d;
    logic               rd_sop_q, rd_sop_d;
    logic               rd_eop_q, rd_eop_d;
    logic               rd_last_q, rd_last_d;

    // Return stage: the cycle mem_rd_data is valid
    logic               pkt_valid_q, pkt_sop_q, pkt_eop_q;
    logic               rd_done_q, mdio_ack_q, busy_q;
    logic [DATA_W-1:0]  mdio_hold_q;

`ifdef PKT_SCHED_HDR_EN
    logic               hdr_pend_q, hdr_pend_d;
    logic [11:0]        seq_q, seq_d;
    logic               rd_hdr_q, rd_hdr_d;
    logic [11:0]        rd_seq_q, rd_seq_d;
    logic               pkt_hdr_q;
    logic [DATA_W-1:0]  hdr_word_q;
`endif

    logic [WCNT_W-1:0]  len_m1;
    logic               mdio_go;
    logic               restart;
    logic               start_pkt;
    logic               last_word;
    logic               end_pkt;

    assign len_m1 = (BASE_LEN << len_sel_q) - WCNT_W'(1);

    // Next-state, slot arbitration and issue-stage decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wcnt_d       = wcnt_q;
        pace_d       = pace_q;
        idle_d       = idle_q;
        again_pend_d = again_pend_q;
        len_sel_d    = len_sel_q;
        idle_sel_d   = idle_sel_q;
        gap_d        = gap_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_pkt_d     = 1'b0;
        rd_mdio_d    = 1'b0;
        rd_sop_d     = 1'b0;
        rd_eop_d     = 1'b0;
        rd_last_d    = 1'b0;
        restart      = 1'b0;
        start_pkt    = 1'b0;
        last_word    = 1'b0;
        end_pkt      = 1'b0;
`ifdef PKT_SCHED_HDR_EN
        hdr_pend_d   = hdr_pend_q;
        seq_d        = seq_q;
        rd_hdr_d     = 1'b0;
        rd_seq_d     = rd_seq_q;
`endif
        mdio_go = mdio_rd_req && !rd_mdio_q;
        if (mdio_go) begin
            rd_en_d   = 1'b1;
            rd_addr_d = mdio_rd_addr;
            rd_mdio_d = 1'b1;
        end

        if ((state_q == PKT || state_q == IDLE_GAP) && capture_again) begin
            again_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                restart = capture_start || capture_again;
            end
            PKT: begin
                if (pace_q != '0) begin
                    pace_d = pace_q - PACE_W'(1);
                end else if (!mdio_go) begin
                    // A slot blocked by MDIO keeps pace at zero and retries next cycle
                    pace_d   = gap_q;
                    rd_pkt_d = 1'b1;
`ifdef PKT_SCHED_HDR_EN
                    if (hdr_pend_q) begin
                        rd_hdr_d   = 1'b1;
                        rd_sop_d   = 1'b1;
                        rd_seq_d   = seq_q;
                        hdr_pend_d = 1'b0;
                        seq_d      = seq_q + 12'd1;
                    end else begin
`endif
                        last_word = (addr_q == LAST_ADDR);
                        end_pkt   = last_word || (wcnt_q == len_m1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q;
`ifndef PKT_SCHED_HDR_EN
                        rd_sop_d  = (wcnt_q == '0);
`endif
                        rd_eop_d  = end_pkt;
                        rd_last_d = last_word;
                        wcnt_d    = wcnt_q + WCNT_W'(1);
                        if (!last_word) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
`ifdef PKT_SCHED_HDR_EN
                    end
`endif
                end
                if (end_pkt) begin
                    if (last_word && !again_pend_d) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE_GAP;
                        idle_d  = {idle_sel_q, 4'hF};
                    end
                end
            end
            IDLE_GAP: begin
                if (idle_q == '0) begin
                    if (again_pend_d) begin
                        restart = 1'b1;
                    end else begin
                        start_pkt = 1'b1;
                    end
                end else begin
                    idle_d = idle_q - IDLE_W'(1);
                end
            end
            DONE: begin
                restart = capture_again;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restart) begin
            addr_d       = '0;
            again_pend_d = 1'b0;
            start_pkt    = 1'b1;
`ifdef PKT_SCHED_HDR_EN
            seq_d        = '0;
`endif
        end

        // Packet start: config is frozen here for the whole packet
        if (start_pkt) begin
            state_d    = PKT;
            wcnt_d     = '0;
            pace_d     = '0;
            len_sel_d  = cfg_data_length;
            idle_sel_d = cfg_idle_length;
            gap_d      = cfg_gap;
`ifdef PKT_SCHED_HDR_EN
            hdr_pend_d = 1'b1;
`endif
        end
    end

    // State, issue-stage and return-stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wcnt_q       <= '0;
            pace_q       <= '0;
            idle_q       <= '0;
            again_pend_q <= 1'b0;
            len_sel_q    <= '0;
            idle_sel_q   <= '0;
            gap_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_pkt_q     <= 1'b0;
            rd_mdio_q    <= 1'b0;
            rd_sop_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            pkt_valid_q  <= 1'b0;
            pkt_sop_q    <= 1'b0;
            pkt_eop_q    <= 1'b0;
            rd_done_q    <= 1'b0;
            mdio_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            mdio_hold_q  <= '0;
`ifdef PKT_SCHED_HDR_EN
            hdr_pend_q   <= 1'b0;
            seq_q        <= '0;
            rd_hdr_q     <= 1'b0;
            rd_seq_q     <= '0;
            pkt_hdr_q    <= 1'b0;
            hdr_word_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wcnt_q       <= wcnt_d;
            pace_q       <= pace_d;
            idle_q       <= idle_d;
            again_pend_q <= again_pend_d;
            len_sel_q    <= len_sel_d;
            idle_sel_q   <= idle_sel_d;
            gap_q        <= gap_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_pkt_q     <= rd_pkt_d;
            rd_mdio_q    <= rd_mdio_d;
            rd_sop_q     <= rd_sop_d;
            rd_eop_q     <= rd_eop_d;
            rd_last_q    <= rd_last_d;
            pkt_valid_q  <= rd_pkt_q;
            pkt_sop_q    <= rd_sop_q;
            pkt_eop_q    <= rd_eop_q;
            rd_done_q    <= rd_last_q;
            mdio_ack_q   <= rd_mdio_q;
            busy_q       <= (state_d == PKT) || (state_d == IDLE_GAP);
            if (mdio_ack_q) begin
                mdio_hold_q <= bus.mem_rd_data;
            end
`ifdef PKT_SCHED_HDR_EN
            hdr_pend_q   <= hdr_pend_d;
            seq_q        <= seq_d;
            rd_hdr_q     <= rd_hdr_d;
            rd_seq_q     <= rd_seq_d;
            pkt_hdr_q    <= rd_hdr_q;
            hdr_word_q   <= DATA_W'({2'b10, 4'd0, rd_seq_q});
`endif
        end
    end

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.pkt_valid   = pkt_valid_q;
    assign bus.pkt_sop     = pkt_sop_q;
    assign bus.pkt_eop     = pkt_eop_q;

    // Returning memory data is forwarded in the return cycle, zero when no word is valid
`ifdef PKT_SCHED_HDR_EN
    assign bus.pkt_data    = pkt_hdr_q ? hdr_word_q : (pkt_valid_q ? bus.mem_rd_data : '0);
`else
    assign bus.pkt_data    = pkt_valid_q ? bus.mem_rd_data : '0;
`endif
    assign mdio_rd_ack     = mdio_ack_q;
    assign mdio_rd_data    = mdio_ack_q ? bus.mem_rd_data : mdio_hold_q;
    assign busy            = busy_q;
    assign rd_done         = rd_done_q;

endmodule

// File: tb/tb_pkt_rd_scheduler.sv
// Directed self-checking bench for pkt_rd_scheduler (default build, no header word).
// A behavioural memory returns addr-derived words; a monitor logs every packet word.
module tb_pkt_rd_scheduler;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 18;

    typedef struct {
        int              cyc;
        logic [DATA_W-1:0] data;
        logic            sop;
        logic            eop;
        logic            done;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cfg_data_length;
    logic [1:0]        cfg_idle_length;
    logic [3:0]        cfg_gap;
    logic              capture_start;
    logic              capture_again;
    logic              mdio_rd_req;
    logic [ADDR_W-1:0] mdio_rd_addr;
    logic              mdio_rd_ack;
    logic [DATA_W-1:0] mdio_rd_data;
    logic              busy;
    logic              rd_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ev_t               log_q[$];
    int                done_cnt = 0;
    int                ack_cnt  = 0;
    int                ack_cyc  = 0;
    logic [DATA_W-1:0] ack_data = '0;

    pkt_rd_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pkt_rd_scheduler #(.ADDR_W(ADDR_W), .MEM_DEPTH(4096), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_data_length (cfg_data_length),
        .cfg_idle_length (cfg_idle_length),
        .cfg_gap         (cfg_gap),
        .capture_start   (capture_start),
        .capture_again   (capture_again),
        .mdio_rd_req     (mdio_rd_req),
        .mdio_rd_addr    (mdio_rd_addr),
        .mdio_rd_ack     (mdio_rd_ack),
        .mdio_rd_data    (mdio_rd_data),
        .busy            (busy),
        .rd_done         (rd_done),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_word(input int a);
        logic [11:0] aa;
        aa = 12'(a);
        return {~aa[5:0], aa};
    endfunction

    // Synchronous-read memory; garbage on idle cycles exposes wrong-cycle sampling
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(int'(bus.mem_rd_addr));
        else               bus.mem_rd_data <= 18'h3BEEF;
    end

    always @(negedge clk) begin
        if (bus.pkt_valid) log_q.push_back('{cyc, bus.pkt_data, bus.pkt_sop, bus.pkt_eop, rd_done});
        if (rd_done) done_cnt++;
        if (mdio_rd_ack) begin
            ack_cnt++;
            ack_cyc  = cyc;
            ack_data = mdio_rd_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ev_t ev(input int i);
        ev_t e;
        e = '{0, '0, 1'b0, 1'b0, 1'b0};
        if (i >= 0 && i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    function automatic int bad_data(input int lo, input int n, input int a0);
        int bad = 0;
        for (int i = 0; i < n; i++) if (ev(lo + i).data !== mem_word(a0 + i)) bad++;
        return bad;
    endfunction

    function automatic int gaps_ne(input int lo, input int n, input int step);
        int bad = 0;
        for (int i = 1; i < n; i++) if (ev(lo + i).cyc - ev(lo + i - 1).cyc != step) bad++;
        return bad;
    endfunction

    function automatic int cnt_sop(input int lo, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (ev(lo + i).sop) c++;
        return c;
    endfunction

    function automatic int cnt_eop(input int lo, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (ev(lo + i).eop) c++;
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        capture_start = 1'b0;
        capture_again = 1'b0;
        mdio_rd_req = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start(output int t);
        t = cyc;
        capture_start = 1'b1;
        tick(1);
        capture_start = 1'b0;
    endtask

    task automatic pulse_again();
        capture_again = 1'b1;
        tick(1);
        capture_again = 1'b0;
    endtask

    initial begin
        int b, b2, d0, a0, t0, tr;

        rst = 1'b1;
        cfg_data_length = 2'd0;
        cfg_idle_length = 2'd0;
        cfg_gap = 4'd0;
        capture_start = 1'b0;
        capture_again = 1'b0;
        mdio_rd_req = 1'b0;
        mdio_rd_addr = '0;
        tick(3);
        check_eq("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_eq("rst_mem_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        check_eq("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("rst_pkt_data", 32'(bus.pkt_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_done", 32'(rd_done), 32'd0);
        check_eq("rst_mdio_ack", 32'(mdio_rd_ack), 32'd0);
        check_eq("rst_mdio_data", 32'(mdio_rd_data), 32'd0);
        rst = 1'b0;
        tick(1);

        // 432-word back-to-back packets, 16 idle cycles
        cfg_data_length = 2'd1; cfg_gap = 4'd0; cfg_idle_length = 2'd0;
        b = log_q.size(); d0 = done_cnt;
        pulse_start(t0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        wait_log(b + 433, 2000, "t1_wait");
        check_eq("t1_latency", 32'(ev(b).cyc - t0), 32'd3);
        check_eq("t1_first_data", 32'(ev(b).data), 32'(mem_word(0)));
        check_eq("t1_first_sop", 32'(ev(b).sop), 32'd1);
        check_eq("t1_data_seq", 32'(bad_data(b, 433, 0)), 32'd0);
        check_eq("t1_back2back", 32'(gaps_ne(b, 432, 1)), 32'd0);
        check_eq("t1_sop_cnt", 32'(cnt_sop(b, 432)), 32'd1);
        check_eq("t1_eop_cnt", 32'(cnt_eop(b, 432)), 32'd1);
        check_eq("t1_eop431", 32'(ev(b + 431).eop), 32'd1);
        check_eq("t1_idle_gap", 32'(ev(b + 432).cyc - ev(b + 431).cyc), 32'd17);
        check_eq("t1_sop432", 32'(ev(b + 432).sop), 32'd1);
        check_eq("t1_no_done", 32'(done_cnt - d0), 32'd0);

        // Paced 216-word packets, one word every 4 cycles
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 4'd3; cfg_idle_length = 2'd0;
        b = log_q.size();
        pulse_start(t0);
        wait_log(b + 217, 2000, "t2_wait");
        check_eq("t2_pacing", 32'(gaps_ne(b, 216, 4)), 32'd0);
        check_eq("t2_data_seq", 32'(bad_data(b, 217, 0)), 32'd0);
        check_eq("t2_eop_cnt", 32'(cnt_eop(b, 216)), 32'd1);
        check_eq("t2_eop215", 32'(ev(b + 215).eop), 32'd1);
        check_eq("t2_sop216", 32'(ev(b + 216).sop), 32'd1);
        check_eq("t2_idle_gap", 32'(ev(b + 216).cyc - ev(b + 215).cyc), 32'd17);

        // 1728-word packets run off the end of memory; third packet is short
        do_reset();
        cfg_data_length = 2'd3; cfg_gap = 4'd0; cfg_idle_length = 2'd1;
        b = log_q.size(); d0 = done_cnt;
        pulse_start(t0);
        wait_log(b + 4096, 6000, "t3_wait");
        tick(40);
        check_eq("t3_done_busy", 32'(busy), 32'd0);
        check_eq("t3_data_seq", 32'(bad_data(b, 4096, 0)), 32'd0);
        check_eq("t3_eop_cnt", 32'(cnt_eop(b, 4096)), 32'd3);
        check_eq("t3_eop1727", 32'(ev(b + 1727).eop), 32'd1);
        check_eq("t3_eop3455", 32'(ev(b + 3455).eop), 32'd1);
        check_eq("t3_idle32", 32'(ev(b + 1728).cyc - ev(b + 1727).cyc), 32'd33);
        check_eq("t3_sop_cnt3", 32'(cnt_sop(b + 3456, 640)), 32'd1);
        check_eq("t3_eop4094", 32'(ev(b + 4094).eop), 32'd0);
        check_eq("t3_eop4095", 32'(ev(b + 4095).eop), 32'd1);
        check_eq("t3_done4095", 32'(ev(b + 4095).done), 32'd1);
        check_eq("t3_done_cnt", 32'(done_cnt - d0), 32'd1);
        pulse_start(t0);
        tick(40);
        check_eq("t3_start_ignored", 32'(log_q.size() - b), 32'd4096);
        pulse_again();
        wait_log(b + 4097, 100, "t3_again_wait");
        check_eq("t3_again_data", 32'(ev(b + 4096).data), 32'(mem_word(0)));
        check_eq("t3_again_sop", 32'(ev(b + 4096).sop), 32'd1);

        // MDIO read steals one slot from a gap=0 stream
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 4'd0; cfg_idle_length = 2'd0;
        b = log_q.size();
        pulse_start(t0);
        wait_log(b + 50, 500, "t4_wait_a");
        a0 = ack_cnt;
        tr = cyc;
        mdio_rd_addr = 12'h123;
        mdio_rd_req = 1'b1;
        tick(2);
        mdio_rd_req = 1'b0;
        for (int k = 0; k < 20 && ack_cnt == a0; k++) tick(1);
        check_eq("t4_ack_lat", 32'(ack_cyc - tr), 32'd2);
        check_eq("t4_ack_data", 32'(ack_data), 32'(mem_word(12'h123)));
        tick(10);
        check_eq("t4_data_hold", 32'(mdio_rd_data), 32'(mem_word(12'h123)));
        check_eq("t4_ack_cnt", 32'(ack_cnt - a0), 32'd1);
        wait_log(b + 216, 500, "t4_wait_b");
        check_eq("t4_data_seq", 32'(bad_data(b, 216, 0)), 32'd0);
        check_eq("t4_bubbles", 32'(gaps_ne(b, 216, 1)), 32'd1);
        check_eq("t4_span", 32'(ev(b + 215).cyc - ev(b).cyc), 32'd216);
        check_eq("t4_eop215", 32'(ev(b + 215).eop), 32'd1);

        // capture_again mid-packet restarts at address 0 after the idle gap
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 4'd0; cfg_idle_length = 2'd0;
        b = log_q.size();
        pulse_start(t0);
        wait_log(b + 101, 500, "t5_wait_a");
        pulse_again();
        wait_log(b + 217, 500, "t5_wait_b");
        check_eq("t5_data_seq", 32'(bad_data(b, 216, 0)), 32'd0);
        check_eq("t5_eop215", 32'(ev(b + 215).eop), 32'd1);
        check_eq("t5_restart_data", 32'(ev(b + 216).data), 32'(mem_word(0)));
        check_eq("t5_restart_sop", 32'(ev(b + 216).sop), 32'd1);
        check_eq("t5_idle_gap", 32'(ev(b + 216).cyc - ev(b + 215).cyc), 32'd17);

        // Reset in the middle of a packet
        do_reset();
        cfg_data_length = 2'd0; cfg_gap = 4'd0; cfg_idle_length = 2'd0;
        b = log_q.size();
        pulse_start(t0);
        wait_log(b + 50, 500, "t6_wait_a");
        rst = 1'b1;
        tick(1);
        check_eq("t6_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check_eq("t6_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_eq("t6_pkt_data", 32'(bus.pkt_data), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        b2 = log_q.size();
        tick(1);
        check_eq("t6_inflight", 32'(bus.pkt_valid), 32'd0);
        tick(5);
        check_eq("t6_quiet", 32'(log_q.size() - b2), 32'd0);
        pulse_start(t0);
        wait_log(b2 + 1, 50, "t6_wait_b");
        check_eq("t6_restart_data", 32'(ev(b2).data), 32'(mem_word(0)));
        check_eq("t6_restart_sop", 32'(ev(b2).sop), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
